regfile_mp: RTL and testbench

- Next-generation register file for the datapath. Generalises the 2-read/1-write 64x32 regfile to configurable width, depth and port counts.
- Adds optional hardwired-zero register, write-to-read bypass, and a per-register pending scoreboard for pipeline hazard detection.
- Adds a sequential clear engine that zeroes the array without asserting reset.

---
 rtl/regfile_mp.sv | 162 ++++++++++++++++
 tb/tb_regfile_mp.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional hardwired zero register,
// same-cycle write-to-read bypass, a per-register pending scoreboard and a
// sequential clear engine.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset (clears array, pending bits, FSM)
//   write_en    per-write-port enable            [NWRITE]
//   write_addr  packed write addresses            [NWRITE*ADDRW]
//   write_data  packed write data                 [NWRITE*WORDSIZE]
//   addr_r      packed read addresses             [NREAD*ADDRW]
//   data_r      packed read data, combinational   [NREAD*WORDSIZE]
//   busy_r      pending bit of each read port's addressed register [NREAD]
//   claim_en    mark claim_addr pending
//   claim_addr  register to mark pending          [ADDRW]
//   clr_req     start a clear sweep (pulse)
//   clr_busy    clear sweep in progress
module regfile_mp #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDRW   = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NWRITE-1:0]          write_en,
  input  logic [NWRITE*ADDRW-1:0]    write_addr,
  input  logic [NWRITE*WORDSIZE-1:0] write_data,
  input  logic [NREAD*ADDRW-1:0]     addr_r,
  output logic [NREAD*WORDSIZE-1:0]  data_r,
  output logic [NREAD-1:0]           busy_r,
  input  logic                       claim_en,
  input  logic [ADDRW-1:0]           claim_addr,
  input  logic                       clr_req,
  output logic                       clr_busy
);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  state_t           state_reg, state_next;
  logic [ADDRW-1:0] idx_reg, idx_next;
  logic             sweeping;

  // Storage is flop-based: reads are combinational and reset must clear
  // every entry asynchronously.
  logic [WORDSIZE-1:0] mem_reg  [SIZE];
  logic                pend_reg [SIZE];

  // ---------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = SWEEP;
          idx_next   = '0;
        end
      end
      SWEEP: begin
        idx_next = idx_reg + ADDRW'(1);
        if (idx_reg == ADDRW'(SIZE - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sweeping = (state_reg == SWEEP);
  assign clr_busy = sweeping;

  // ---------------------------------------------------------------------
  // Per-register update: data and pending bit
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_reg
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

      logic                wr_hit;
      logic [WORDSIZE-1:0] wr_val;
      logic                clm_hit;
      logic                clr_hit;

      // Later ports override earlier ones, so port 1 wins on a collision.
      always_comb begin
        wr_hit = 1'b0;
        wr_val = '0;
        for (int k = 0; k < NWRITE; k++) begin
          if (write_en[k] && (write_addr[k*ADDRW +: ADDRW] == ADDRW'(gi))) begin
            wr_hit = 1'b1;
            wr_val = write_data[k*WORDSIZE +: WORDSIZE];
          end
        end
      end

      assign clm_hit = claim_en && (claim_addr == ADDRW'(gi));
      assign clr_hit = sweeping && (idx_reg == ADDRW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi]  <= '0;
          pend_reg[gi] <= 1'b0;
        end else if (sweeping) begin
          // Writes and claims are dropped for the whole sweep.
          if (clr_hit) begin
            mem_reg[gi]  <= '0;
            pend_reg[gi] <= 1'b0;
          end
        end else begin
          if (wr_hit && !IS_ZERO) mem_reg[gi] <= wr_val;
          // A claim issued alongside the retiring write re-arms the hazard.
          if (clm_hit && !IS_ZERO)  pend_reg[gi] <= 1'b1;
          else if (wr_hit)          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [ADDRW-1:0]    ra;
      logic [WORDSIZE-1:0] rd;

      assign ra = addr_r[gi*ADDRW +: ADDRW];

      always_comb begin
        rd = mem_reg[ra];
        // Forward only writes that will actually land; during a sweep they
        // are dropped, so the array contents are the truth.
        if ((BYPASS != 0) && !sweeping) begin
          for (int k = 0; k < NWRITE; k++) begin
            if (write_en[k] && (write_addr[k*ADDRW +: ADDRW] == ra))
              rd = write_data[k*WORDSIZE +: WORDSIZE];
          end
        end
        if (((ZERO_REG != 0) && (ra == '0)) || !rst_n) rd = '0;
      end

      assign data_r[gi*WORDSIZE +: WORDSIZE] = rd;
      assign busy_r[gi] = pend_reg[ra];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int W  = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: two write ports, bypass and zero register enabled.
  logic [1:0]      write_en;
  logic [2*AW-1:0] write_addr;
  logic [2*W-1:0]  write_data;
  logic [2*AW-1:0] addr_r;
  logic [2*W-1:0]  data_r;
  logic [1:0]      busy_r;
  logic            claim_en;
  logic [AW-1:0]   claim_addr;
  logic            clr_req;
  logic            clr_busy;

  // Second DUT: bypass disabled.
  logic            nb_we;
  logic [AW-1:0]   nb_wa;
  logic [W-1:0]    nb_wd;
  logic [2*AW-1:0] nb_ra;
  logic [2*W-1:0]  nb_data;
  logic [1:0]      nb_busy;
  logic            nb_clr_busy;

  regfile_mp #(.NWRITE(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .addr_r(addr_r), .data_r(data_r), .busy_r(busy_r),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .write_en(nb_we), .write_addr(nb_wa), .write_data(nb_wd),
    .addr_r(nb_ra), .data_r(nb_data), .busy_r(nb_busy),
    .claim_en(1'b0), .claim_addr(5'd0),
    .clr_req(1'b0), .clr_busy(nb_clr_busy)
  );

  // Scoreboard of expected values.
  typedef struct {
    string      nm;
    logic [W-1:0] v;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string nm, input logic [W-1:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [W-1:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h, nothing expected", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.nm, act, e.v);
      end else begin
        $display("ok   %s: %h", e.nm, act);
      end
    end
  endtask

  // Table-driven vectors: inputs plus expected combinational outputs
  // observed before the edge that commits the inputs.
  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [W-1:0]  wd0;
    logic [AW-1:0] wa1;
    logic [W-1:0]  wd1;
    logic          claim;
    logic [AW-1:0] ca;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
    logic [1:0]    eb;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] we, input logic [AW-1:0] wa0,
                              input logic [W-1:0] wd0, input logic [AW-1:0] wa1,
                              input logic [W-1:0] wd1, input logic claim,
                              input logic [AW-1:0] ca, input logic [AW-1:0] ra0,
                              input logic [AW-1:0] ra1, input logic [W-1:0] e0,
                              input logic [W-1:0] e1, input logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.claim = claim; v.ca = ca; v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  function automatic logic [W-1:0] fill(input int i);
    return 64'h0123_4567_0000_0000 | 64'(i);
  endfunction

  task automatic idle();
    write_en = '0;
    claim_en = 1'b0;
    clr_req  = 1'b0;
    nb_we    = 1'b0;
  endtask

  localparam logic [W-1:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [W-1:0] F = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int cnt;
    idle();
    write_addr = '0; write_data = '0; addr_r = '0; claim_addr = '0;
    nb_wa = '0; nb_wd = '0; nb_ra = '0;
    #12 rst_n = 1'b1;
    @(posedge clk) #1;

    // ---- Asynchronous reset, mid-cycle, no edge needed ----
    write_en = 2'b01; write_addr = {5'd0, 5'd1}; write_data = {64'd0, 64'hDEAD};
    claim_en = 1'b1;  claim_addr = 5'd1;
    @(posedge clk) #1;
    idle();
    addr_r = {5'd2, 5'd1};
    #1;
    push("pre_reset_r1", 64'hDEAD); cmp(data_r[W-1:0]);
    push("pre_reset_busy", 64'd1);  cmp(64'(busy_r));
    rst_n = 1'b0;
    #1;
    push("reset_d0", 64'd0);      cmp(data_r[W-1:0]);
    push("reset_d1", 64'd0);      cmp(data_r[2*W-1:W]);
    push("reset_busy", 64'd0);    cmp(64'(busy_r));
    push("reset_clr_busy", 64'd0); cmp(64'(clr_busy));
    #1 rst_n = 1'b1;
    @(posedge clk) #1;

    // ---- Table-driven vectors on the bypassing DUT ----
    vecs.push_back(mk(2'b01, 5'd1, A,        5'd0, 64'd0,    1'b0, 5'd0, 5'd1, 5'd2, A,        64'd0,    2'b00));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b0, 5'd0, 5'd1, 5'd2, A,        64'd0,    2'b00));
    vecs.push_back(mk(2'b01, 5'd0, 64'h1234, 5'd0, 64'd0,    1'b0, 5'd0, 5'd0, 5'd1, 64'd0,    A,        2'b00));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b0, 5'd0, 5'd0, 5'd1, 64'd0,    A,        2'b00));
    vecs.push_back(mk(2'b11, 5'd4, 64'h1111, 5'd4, 64'h2222, 1'b0, 5'd0, 5'd4, 5'd4, 64'h2222, 64'h2222, 2'b00));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b0, 5'd0, 5'd4, 5'd1, 64'h2222, A,        2'b00));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b1, 5'd5, 5'd5, 5'd4, 64'd0,    64'h2222, 2'b00));
    vecs.push_back(mk(2'b01, 5'd5, 64'h55,   5'd0, 64'd0,    1'b1, 5'd5, 5'd5, 5'd1, 64'h55,   A,        2'b01));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b0, 5'd0, 5'd5, 5'd1, 64'h55,   A,        2'b01));
    vecs.push_back(mk(2'b01, 5'd5, 64'h66,   5'd0, 64'd0,    1'b0, 5'd0, 5'd5, 5'd5, 64'h66,   64'h66,   2'b11));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b0, 5'd0, 5'd5, 5'd4, 64'h66,   64'h2222, 2'b00));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b1, 5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    2'b00));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b0, 5'd0, 5'd0, 5'd0, 64'd0,    64'd0,    2'b00));
    vecs.push_back(mk(2'b11, 5'd3, 64'h77,   5'd3, 64'h33,   1'b0, 5'd0, 5'd3, 5'd2, 64'h33,   64'd0,    2'b00));
    vecs.push_back(mk(2'b00, 5'd0, 64'd0,    5'd0, 64'd0,    1'b0, 5'd0, 5'd3, 5'd2, 64'h33,   64'd0,    2'b00));

    foreach (vecs[n]) begin
      write_en   = vecs[n].we;
      write_addr = {vecs[n].wa1, vecs[n].wa0};
      write_data = {vecs[n].wd1, vecs[n].wd0};
      claim_en   = vecs[n].claim;
      claim_addr = vecs[n].ca;
      addr_r     = {vecs[n].ra1, vecs[n].ra0};
      push($sformatf("vec%0d_d0", n), vecs[n].e0);
      push($sformatf("vec%0d_d1", n), vecs[n].e1);
      push($sformatf("vec%0d_busy", n), 64'(vecs[n].eb));
      @(negedge clk);
      cmp(data_r[W-1:0]);
      cmp(data_r[2*W-1:W]);
      cmp(64'(busy_r));
      @(posedge clk) #1;
    end
    idle();

    // ---- No bypass: new value visible only after the edge ----
    nb_we = 1'b1; nb_wa = 5'd2; nb_wd = F; nb_ra = {5'd0, 5'd2};
    push("nobyp_r2_before_edge", 64'd0);
    @(negedge clk) cmp(nb_data[W-1:0]);
    @(posedge clk) #1;
    nb_we = 1'b0;
    push("nobyp_r2_after_edge", F);
    #1 cmp(nb_data[W-1:0]);
    nb_we = 1'b1; nb_wa = 5'd0; nb_wd = F; nb_ra = {5'd2, 5'd0};
    push("nobyp_r0_during_write", 64'd0);
    @(negedge clk) cmp(nb_data[W-1:0]);
    @(posedge clk) #1;
    nb_we = 1'b0;
    push("nobyp_r0_after_write", 64'd0);
    #1 cmp(nb_data[W-1:0]);

    // ---- Clear sweep ----
    for (int i = 1; i < 32; i++) begin
      write_en   = 2'b01;
      write_addr = {5'd0, 5'(i)};
      write_data = {64'd0, fill(i)};
      claim_en   = (i == 7);
      claim_addr = 5'd7;
      @(posedge clk) #1;
    end
    idle();
    addr_r = {5'd7, 5'd31};
    #1;
    push("fill_r31", fill(31)); cmp(data_r[W-1:0]);
    push("fill_busy_r7", 64'd2); cmp(64'(busy_r));
    clr_req = 1'b1;
    @(posedge clk) #1;
    clr_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!clr_busy) break;
      if (cnt == 0) begin
        push("sweep_start_r31_intact", fill(31)); cmp(data_r[W-1:0]);
      end
      if (cnt == 10) begin
        write_en = 2'b01; write_addr = {5'd0, 5'd2}; write_data = {64'd0, 64'hBEEF};
        claim_en = 1'b1; claim_addr = 5'd2;
        addr_r = {5'd2, 5'd2};
        #1;
        push("sweep_write_not_forwarded", 64'd0); cmp(data_r[W-1:0]);
      end
      if (cnt == 11) idle();
      cnt++;
    end
    idle();
    push("clr_busy_cycles", 64'd32); cmp(64'(cnt));
    for (int j = 0; j < 16; j++) begin
      addr_r = {5'(2*j+1), 5'(2*j)};
      #1;
      push($sformatf("cleared_r%0d", 2*j), 64'd0);   cmp(data_r[W-1:0]);
      push($sformatf("cleared_r%0d", 2*j+1), 64'd0); cmp(data_r[2*W-1:W]);
      push($sformatf("cleared_busy_%0d", j), 64'd0); cmp(64'(busy_r));
    end

    // ---- Reset aborts a sweep ----
    @(posedge clk) #1;
    write_en = 2'b01; write_addr = {5'd0, 5'd9}; write_data = {64'd0, fill(9)};
    @(posedge clk) #1;
    idle();
    addr_r = {5'd9, 5'd31};
    clr_req = 1'b1;
    @(posedge clk) #1;
    clr_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!clr_busy) break;
      if (cnt == 10) break;
      cnt++;
    end
    push("abort_reached_cycle10", 64'd10); cmp(64'(cnt));
    rst_n = 1'b0;
    #1;
    push("abort_clr_busy", 64'd0); cmp(64'(clr_busy));
    push("abort_r9_reset", 64'd0); cmp(data_r[2*W-1:W]);
    #1 rst_n = 1'b1;
    @(posedge clk) #1;
    push("abort_stays_idle", 64'd0); cmp(64'(clr_busy));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
